spi_frame_scheduler: RTL



---
 rtl/spi_frame_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_scheduler.sv
// SPI frame scheduler: buffers counter and command requests, arbitrates between them and
// sequences slave select, setup, two byte transfers and the inter-frame gap for the shifter.
module spi_frame_scheduler #(
  parameter int SETUP_CYCLES   = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cnt_valid,
  input  logic [13:0] i_cnt_data,
  input  logic        i_cmd_valid,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_ready,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_done,
  output logic        o_ss,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_timeout,
  output logic [7:0]  o_drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, SETUP, B0_START, B0_WAIT, B1_START, B1_WAIT, GAP
  } state_t;

  typedef enum logic {SRC_CNT, SRC_CMD} src_t;

  localparam int MAX_SG    = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int MAX_COUNT = (TIMEOUT_CYCLES > MAX_SG) ? TIMEOUT_CYCLES : MAX_SG;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  src_t          last_grant;
  logic [CW-1:0] timer;
  logic          cnt_pending, cmd_pending;
  logic [13:0]   cnt_buf;
  logic [7:0]    cmd_buf;
  logic [7:0]    frame_b0, frame_b1;
  logic          grant_cnt, grant_cmd;
  logic          cmd_accept;

  assign o_cmd_ready = ~cmd_pending;
  assign cmd_accept  = i_cmd_valid & ~cmd_pending;

  // NOTE: every path assigns a default first so no latch is inferred.
  always_comb begin
    grant_cnt = 1'b0;
    grant_cmd = 1'b0;
    if (state == IDLE) begin
      if (cnt_pending && cmd_pending) begin
        grant_cnt = (last_grant == SRC_CMD);
        grant_cmd = (last_grant == SRC_CNT);
      end else begin
        grant_cnt = cnt_pending;
        grant_cmd = cmd_pending;
      end
    end
  end

  // Pending flags and drop counter; last_grant only moves when both requesters competed.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_pending <= 1'b0;
      cmd_pending <= 1'b0;
      o_drop_cnt  <= 8'd0;
      last_grant  <= SRC_CMD;
    end else begin
      if (i_cnt_valid) begin
        cnt_pending <= 1'b1;
        if (cnt_pending && !grant_cnt && o_drop_cnt != 8'hFF)
          o_drop_cnt <= o_drop_cnt + 8'd1;
      end else if (grant_cnt) begin
        cnt_pending <= 1'b0;
      end
      if (cmd_accept)
        cmd_pending <= 1'b1;
      else if (grant_cmd)
        cmd_pending <= 1'b0;
      if (cnt_pending && cmd_pending && state == IDLE)
        last_grant <= grant_cnt ? SRC_CNT : SRC_CMD;
    end
  end

  // NOTE: pure data registers carry no reset; their pending/state qualifiers do.
  always_ff @(posedge clk) begin
    if (i_cnt_valid) cnt_buf <= i_cnt_data;
    if (cmd_accept)  cmd_buf <= i_cmd_data;
    if (grant_cnt) begin
      frame_b0 <= {2'b10, cnt_buf[13:8]};
      frame_b1 <= cnt_buf[7:0];
    end else if (grant_cmd) begin
      frame_b0 <= 8'h40;
      frame_b1 <= cmd_buf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      o_ss         <= 1'b1;
      o_tx_start   <= 1'b0;
      o_tx_data    <= 8'd0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_tx_start   <= 1'b0;
      o_frame_done <= 1'b0;
      o_timeout    <= 1'b0;
      case (state)
        IDLE: if (grant_cnt || grant_cmd) begin
          state  <= SETUP;
          timer  <= '0;
          o_ss   <= 1'b0;
          o_busy <= 1'b1;
        end
        SETUP: if (timer == SETUP_LAST) begin
          state      <= B0_START;
          o_tx_start <= 1'b1;
          o_tx_data  <= frame_b0;
        end else begin
          timer <= timer + CW'(1);
        end
        B0_START: begin
          state <= B0_WAIT;
          timer <= CW'(1);
        end
        B0_WAIT: if (i_tx_done) begin
          state      <= B1_START;
          o_tx_start <= 1'b1;
          o_tx_data  <= frame_b1;
        end else if (timer == TIMEOUT_LAST) begin
          state     <= GAP;
          timer     <= '0;
          o_ss      <= 1'b1;
          o_timeout <= 1'b1;
        end else begin
          timer <= timer + CW'(1);
        end
        B1_START: begin
          state <= B1_WAIT;
          timer <= CW'(1);
        end
        B1_WAIT: if (i_tx_done) begin
          state        <= GAP;
          timer        <= '0;
          o_ss         <= 1'b1;
          o_frame_done <= 1'b1;
        end else if (timer == TIMEOUT_LAST) begin
          state     <= GAP;
          timer     <= '0;
          o_ss      <= 1'b1;
          o_timeout <= 1'b1;
        end else begin
          timer <= timer + CW'(1);
        end
        GAP: if (timer == GAP_LAST) begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end else begin
          timer <= timer + CW'(1);
        end
        default: begin
          state  <= IDLE;
          o_ss   <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
